op_amp_step_sequencer: RTL
==========================

// Module: op_amp_step_sequencer
// PURPOSE
//  Sample-rate scheduler for the floating-point op-amp loop. It replaces the free-running
//  divided clock with single-cycle strobes on the system clock, and steps one shared
//  float multiplier through the two products: square, then gain.
//  It orders the register loads: square -> sum (convert minus square) -> gain product
//  -> IIR filter step. It sits between the top-level clock/reset and the datapath registers.
// PARAMETERS
//  DIV_COUNT    1000  system cycles per sample period; legal range 16..65535
//  MUL_TIMEOUT  64    max cycles to wait for mul_done before aborting a step; legal range 2..255
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  reset_n      in   1   synchronous, active-low reset
//  run_en       in   1   1 = sample ticks generated; 0 = divider held at 0
//  mul_done     in   1   shared multiplier result valid (1-cycle pulse)
//  clear_err    in   1   clears the overrun and timeout sticky flags
//  mul_sel      out  1   operand mux: 0 = filter_out x filter_out, 1 = gain x sum
//  mul_start    out  1   1-cycle pulse; multiplier captures its operands
//  sq_load      out  1   1-cycle pulse; square register loads the multiplier result
//  sum_load     out  1   1-cycle pulse; sum register loads the subtractor output
//  gain_load    out  1   1-cycle pulse; mul_out register loads the multiplier result
//  filt_step    out  1   1-cycle pulse; IIR filter advances one sample
//  sample_done  out  1   1-cycle pulse; square_out is updated and stable
//  busy         out  1   1 whenever the FSM is not in IDLE
//  overrun      out  1   sticky; a tick arrived while busy
//  timeout      out  1   sticky; mul_done was not seen within MUL_TIMEOUT cycles
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - all outputs 0; mul_sel=0; divider=0; FSM=IDLE; wait counter=0.
//   - a reset mid-sequence aborts it, and no load pulse is issued in that cycle.
//  Divider:
//   - counts 0..DIV_COUNT-1 while run_en=1; tick is internal and 1 when count==DIV_COUNT-1.
//   - run_en=0 clears the count to 0 and suppresses tick.
//  FSM (registered state; every output is a registered decode, 1 cycle after the transition):
//   - IDLE   : tick -> SQ_REQ.
//   - SQ_REQ : mul_sel=0, mul_start=1 -> SQ_WAIT.
//   - SQ_WAIT: mul_done -> SQ_LD; wait count hits MUL_TIMEOUT -> ABORT.
//   - SQ_LD  : sq_load=1 -> SUM_LD.
//   - SUM_LD : sum_load=1 -> G_REQ.
//   - G_REQ  : mul_sel=1, mul_start=1 -> G_WAIT.
//   - G_WAIT : mul_done -> G_LD; timeout -> ABORT.
//   - G_LD   : gain_load=1 -> FILT.
//   - FILT   : filt_step=1 -> DONE.
//   - DONE   : sample_done=1 -> IDLE.
//   - ABORT  : timeout<=1 -> IDLE; no further load pulses for that sample.
//  mul_sel rules:
//   - mul_sel is held from its REQ state through its WAIT and LD states.
//   - mul_sel returns to 0 in IDLE.
//  Wait counter:
//   - 8-bit; cleared on entering SQ_WAIT and G_WAIT; increments each WAIT cycle.
//   - timeout fires when count==MUL_TIMEOUT-1 and mul_done=0.
//  mul_done handling:
//   - ignored outside the WAIT states.
//   - if mul_done arrives in the same cycle as the timeout condition, mul_done wins.
//  Latency: tick -> sample_done = 7 cycles + 2 x (multiplier latency).
//  Overrun:
//   - a tick while busy=1 sets overrun; that tick is dropped and the sequence in flight completes.
//   - clear_err=1 clears both sticky flags; a set event in the same cycle wins over the clear.
//  run_en dropped mid-sequence: the current sequence still completes; no new ticks are generated.
// CONFIGURATION
//  SEQ_SAMPLE_CNT_EN defined:
//   - adds output sample_cnt[15:0].
//   - increments on each sample_done; wraps 0xFFFF -> 0; cleared by reset.
//   - not incremented on an ABORTed sample.
//  SEQ_SAMPLE_CNT_EN undefined: no sample_cnt port and no counter logic; all other behaviour identical.
// TESTING
//  T1 DIV_COUNT=16, run_en=1, mul_done 2 cycles after each mul_start
//     -> pulse order sq_load, sum_load, gain_load, filt_step, sample_done;
//        sample_done 11 cycles after tick; one sample every 16 cycles; overrun=0.
//  T2 mul_done 12 cycles after mul_start, DIV_COUNT=16
//     -> second tick arrives while busy: overrun=1, no extra mul_start;
//        clear_err pulse -> overrun=0.
//  T3 mul_done never asserted, MUL_TIMEOUT=8
//     -> timeout=1 8 cycles after mul_start; FSM back in IDLE;
//        sq_load, sum_load and gain_load never pulse.
//  T4 reset_n=0 for 1 cycle while in G_WAIT
//     -> next cycle: all outputs 0, busy=0, no gain_load; the next tick starts a clean sequence.
//  T5 mul_done coincident with the timeout cycle -> LD state taken; timeout stays 0.
//  T6 (SEQ_SAMPLE_CNT_EN) preload sample_cnt to 0xFFFE via forced samples
//     -> two sample_done pulses give 0xFFFF then 0x0000.

Source files
------------

// File: rtl/op_amp_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// op_amp_step_sequencer_if
// Control bundle between the step sequencer and the op-amp datapath.
// Revision: 1.0
// ============================================================================
interface op_amp_step_sequencer_if;
  logic        run_en;
  logic        mul_done;
  logic        clear_err;
  logic        mul_sel;
  logic        mul_start;
  logic        sq_load;
  logic        sum_load;
  logic        gain_load;
  logic        filt_step;
  logic        sample_done;
  logic        busy;
  logic        overrun;
  logic        timeout;
`ifdef SEQ_SAMPLE_CNT_EN
  logic [15:0] sample_cnt;
`endif

  modport master (
    input  run_en, mul_done, clear_err,
    output mul_sel, mul_start, sq_load, sum_load, gain_load, filt_step,
           sample_done, busy, overrun, timeout
`ifdef SEQ_SAMPLE_CNT_EN
    , output sample_cnt
`endif
  );

  modport slave (
    output run_en, mul_done, clear_err,
    input  mul_sel, mul_start, sq_load, sum_load, gain_load, filt_step,
           sample_done, busy, overrun, timeout
`ifdef SEQ_SAMPLE_CNT_EN
    , input sample_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/op_amp_step_sequencer.sv
`default_nettype none
// ============================================================================
// op_amp_step_sequencer
// Sample-tick divider and sequencer stepping one shared multiplier through
// square then gain. Optional macro SEQ_SAMPLE_CNT_EN adds sample_cnt.
// Revision: 1.0
// ============================================================================
module op_amp_step_sequencer #(
  parameter int DIV_COUNT   = 1000,
  parameter int MUL_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  op_amp_step_sequencer_if.master io_seq
);

  localparam logic [15:0] c_div_last  = 16'(DIV_COUNT - 1);
  localparam logic [7:0]  c_wait_last = 8'(MUL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SQ_REQ  = 4'd1,
    S_SQ_WAIT = 4'd2,
    S_SQ_LD   = 4'd3,
    S_SUM_LD  = 4'd4,
    S_G_REQ   = 4'd5,
    S_G_WAIT  = 4'd6,
    S_G_LD    = 4'd7,
    S_FILT    = 4'd8,
    S_DONE    = 4'd9,
    S_ABORT   = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_div_cnt;
  logic [7:0]  r_wait_cnt;
  logic        w_tick;
  logic        w_wait_expired;

  logic r_mul_sel;
  logic r_mul_start;
  logic r_sq_load;
  logic r_sum_load;
  logic r_gain_load;
  logic r_filt_step;
  logic r_sample_done;
  logic r_busy;
  logic r_overrun;
  logic r_timeout;

  assign w_tick         = io_seq.run_en && (r_div_cnt == c_div_last);
  assign w_wait_expired = (r_wait_cnt == c_wait_last);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (!io_seq.run_en || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // mul_done is only looked at in the WAIT states and beats a same-cycle expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_tick) w_next = S_SQ_REQ;
      S_SQ_REQ:  w_next = S_SQ_WAIT;
      S_SQ_WAIT: begin
        if (io_seq.mul_done)     w_next = S_SQ_LD;
        else if (w_wait_expired) w_next = S_ABORT;
      end
      S_SQ_LD:   w_next = S_SUM_LD;
      S_SUM_LD:  w_next = S_G_REQ;
      S_G_REQ:   w_next = S_G_WAIT;
      S_G_WAIT:  begin
        if (io_seq.mul_done)     w_next = S_G_LD;
        else if (w_wait_expired) w_next = S_ABORT;
      end
      S_G_LD:    w_next = S_FILT;
      S_FILT:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      S_ABORT:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SQ_REQ || r_state == S_G_REQ) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SQ_WAIT || r_state == S_G_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mul_sel     <= 1'b0;
      r_mul_start   <= 1'b0;
      r_sq_load     <= 1'b0;
      r_sum_load    <= 1'b0;
      r_gain_load   <= 1'b0;
      r_filt_step   <= 1'b0;
      r_sample_done <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_mul_start   <= (w_next == S_SQ_REQ) || (w_next == S_G_REQ);
      r_sq_load     <= (w_next == S_SQ_LD);
      r_sum_load    <= (w_next == S_SUM_LD);
      r_gain_load   <= (w_next == S_G_LD);
      r_filt_step   <= (w_next == S_FILT);
      r_sample_done <= (w_next == S_DONE);
      r_busy        <= (w_next != S_IDLE);

      if (w_next == S_G_REQ) begin
        r_mul_sel <= 1'b1;
      end else if (w_next == S_IDLE || w_next == S_SQ_REQ) begin
        r_mul_sel <= 1'b0;
      end

      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (io_seq.clear_err) begin
        r_overrun <= 1'b0;
      end

      if (w_next == S_ABORT) begin
        r_timeout <= 1'b1;
      end else if (io_seq.clear_err) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign io_seq.mul_sel     = r_mul_sel;
  assign io_seq.mul_start   = r_mul_start;
  assign io_seq.sq_load     = r_sq_load;
  assign io_seq.sum_load    = r_sum_load;
  assign io_seq.gain_load   = r_gain_load;
  assign io_seq.filt_step   = r_filt_step;
  assign io_seq.sample_done = r_sample_done;
  assign io_seq.busy        = r_busy;
  assign io_seq.overrun     = r_overrun;
  assign io_seq.timeout     = r_timeout;

`ifdef SEQ_SAMPLE_CNT_EN
  logic [15:0] r_sample_cnt;

  // Counts only completed samples; an aborted sample never reaches DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sample_cnt <= '0;
    end else if (w_next == S_DONE) begin
      r_sample_cnt <= r_sample_cnt + 16'd1;
    end
  end

  assign io_seq.sample_cnt = r_sample_cnt;
`endif

endmodule
`default_nettype wire
